dht_responder: RTL and testbench

//  Single-wire DHT11-style sensor responder (slave end of the humidity/temperature bus).

---
 rtl/dht_responder.sv | 168 ++++++++++++++++
 tb/tb_dht_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dht_responder.sv
// DHT11-style single-wire sensor responder: waits for a host start pulse, then
// sends the response preamble and a 40-bit humidity/temperature frame.
//
// state    | meaning
// IDLE     | line released, waiting for the host to pull low
// HOST_LOW | timing the host low pulse
// WAIT_REL | host released, delay before responding
// RESP_LO  | response preamble, line driven low
// RESP_HI  | response preamble, line released
// BIT_LO   | low slot preceding each data bit
// BIT_HI   | released slot whose length encodes the bit
// END_LO   | closing low slot after the last bit
module dht_responder #(
  parameter int unsigned START_MIN = 900000,
  parameter int unsigned HOST_WAIT = 1500,
  parameter int unsigned RESP_LOW  = 4000,
  parameter int unsigned RESP_HIGH = 4000,
  parameter int unsigned BIT_LOW   = 2500,
  parameter int unsigned ZERO_HIGH = 1300,
  parameter int unsigned ONE_HIGH  = 3500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dq_in,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       dq_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, HOST_LOW, WAIT_REL, RESP_LO, RESP_HI, BIT_LO, BIT_HI, END_LO
  } state_t;

  localparam logic [19:0] START_MIN_C = 20'(START_MIN);

  state_t      state, state_next;
  logic        dq_m, dq_s;
  logic [19:0] cnt;
  logic [19:0] phase_len;
  logic        phase_end;
  logic [5:0]  bit_cnt;
  logic [39:0] sreg;
  logic [7:0]  csum;
  logic        load, shift, done_set, err_set;

  assign csum = hum_int + hum_dec + temp_int + temp_dec;

  always_comb begin
    phase_len = 20'd0;
    case (state)
      WAIT_REL: phase_len = 20'(HOST_WAIT);
      RESP_LO:  phase_len = 20'(RESP_LOW);
      RESP_HI:  phase_len = 20'(RESP_HIGH);
      BIT_LO:   phase_len = 20'(BIT_LOW);
      BIT_HI:   phase_len = sreg[39] ? 20'(ONE_HIGH) : 20'(ZERO_HIGH);
      END_LO:   phase_len = 20'(BIT_LOW);
      default:  phase_len = 20'd0;
    endcase
  end

  assign phase_end = (cnt == phase_len - 20'd1);

  // State register plus the phase/bit datapath; the synchronizer idles high like the pulled-up line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dq_m    <= 1'b1;
      dq_s    <= 1'b1;
      cnt     <= 20'd0;
      bit_cnt <= 6'd0;
      sreg    <= 40'd0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_next;
      dq_m  <= dq_in;
      dq_s  <= dq_m;
      done  <= done_set;
      err   <= err_set;
      if (state_next != state || state == IDLE) begin
        cnt <= 20'd0;
      end else if (cnt != 20'hFFFFF) begin
        cnt <= cnt + 20'd1;
      end
      if (load) begin
        sreg    <= {hum_int, hum_dec, temp_int, temp_dec, csum};
        bit_cnt <= 6'd0;
      end else if (shift) begin
        sreg    <= {sreg[38:0], 1'b0};
        bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: if (!dq_s) state_next = HOST_LOW;
      HOST_LOW: begin
        if (dq_s) begin
          if (cnt >= START_MIN_C) begin
            state_next = WAIT_REL;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      WAIT_REL: if (phase_end) state_next = RESP_LO;
      RESP_LO:  if (phase_end) state_next = RESP_HI;
      RESP_HI: begin
        if (phase_end) begin
          if (!dq_s) begin
            state_next = IDLE;
            err_set    = 1'b1;
          end else begin
            state_next = BIT_LO;
          end
        end
      end
      BIT_LO: if (phase_end) state_next = BIT_HI;
      BIT_HI: begin
        if (phase_end) begin
          if (!dq_s) begin
            state_next = IDLE;
            err_set    = 1'b1;
          end else begin
            shift      = 1'b1;
            state_next = (bit_cnt == 6'd39) ? END_LO : BIT_LO;
          end
        end
      end
      END_LO: begin
        if (phase_end) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dq_oe = 1'b0;
    busy  = 1'b0;
    case (state)
      WAIT_REL, RESP_HI, BIT_HI: busy = 1'b1;
      RESP_LO, BIT_LO, END_LO: begin
        dq_oe = 1'b1;
        busy  = 1'b1;
      end
      default: begin
        dq_oe = 1'b0;
        busy  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dht_responder.sv
// Bench for dht_responder with scaled-down phase lengths; a line monitor decodes
// each frame from dq_oe and checks it against a queue of expected frames/aborts.
module tb_dht_responder;

  localparam int T_START_MIN = 100;
  localparam int T_HOST_WAIT = 15;
  localparam int T_RESP_LOW  = 40;
  localparam int T_RESP_HIGH = 40;
  localparam int T_BIT_LOW   = 25;
  localparam int T_ZERO_HIGH = 13;
  localparam int T_ONE_HIGH  = 35;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dq_in;
  logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
  logic       dq_oe, busy, done, err;
  logic       host_low = 1'b0;
  logic       contend  = 1'b0;

  assign dq_in = ~(dq_oe | host_low | contend);

  dht_responder #(
    .START_MIN(T_START_MIN), .HOST_WAIT(T_HOST_WAIT), .RESP_LOW(T_RESP_LOW),
    .RESP_HIGH(T_RESP_HIGH), .BIT_LOW(T_BIT_LOW), .ZERO_HIGH(T_ZERO_HIGH),
    .ONE_HIGH(T_ONE_HIGH)
  ) dut (
    .clk(clk), .rst(rst), .dq_in(dq_in),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .dq_oe(dq_oe), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [39:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: run-length decode of dq_oe, sampled on the falling edge.
  bit          in_frame = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_oe = 1'b0;
  int          run_len = 0;
  int          nruns = 0;
  int          nbits = 0;
  logic [39:0] rx = 40'd0;

  task automatic handle_run(input logic level, input int len);
    if (nruns == 0) chk("wait_len", len, T_HOST_WAIT);
    else if (nruns == 1) chk("resp_low", len, T_RESP_LOW);
    else if (nruns == 2) chk("resp_high", len, T_RESP_HIGH);
    else if (level) chk(nbits == 40 ? "end_low" : "bit_low", len, T_BIT_LOW);
    else begin
      n_cmp++;
      if (len == T_ZERO_HIGH) rx = {rx[38:0], 1'b0};
      else if (len == T_ONE_HIGH) rx = {rx[38:0], 1'b1};
      else begin
        n_bad++;
        rx = {rx[38:0], 1'b0};
        $display("FAIL bit_width: bit %0d high for %0d cycles, expected %0d or %0d",
                 nbits, len, T_ZERO_HIGH, T_ONE_HIGH);
      end
      nbits++;
    end
    nruns++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame  = 1'b0;
        prev_busy = 1'b0;
      end else begin
        if (in_frame) begin
          if (dq_oe == prev_oe) run_len++;
          else begin
            handle_run(prev_oe, run_len);
            prev_oe = dq_oe;
            run_len = 1;
          end
        end
        if (busy && !prev_busy) begin
          in_frame = 1'b1;
          prev_oe  = dq_oe;
          run_len  = 1;
          nruns    = 0;
          nbits    = 0;
          rx       = 40'd0;
        end
        if (done || err) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: done=%0b err=%0b with nothing expected", done, err);
          end else begin
            e = sb_q.pop_front();
            chk("event_kind", {63'd0, err}, {63'd0, e.is_err});
            chk("oe_at_end", {63'd0, dq_oe}, 64'd0);
            chk("busy_at_end", {63'd0, busy}, 64'd0);
            if (!e.is_err) begin
              chk("frame_data", rx, e.data);
              chk("frame_bits", nbits, 40);
            end
          end
          in_frame = 1'b0;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic start_pulse(input int len);
    @(negedge clk);
    host_low = 1'b1;
    repeat (len) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, {63'd0, n >= bound}, 64'd0);
    repeat (20) @(negedge clk);
  endtask

  // which: 0 = dq_oe, 1 = err, 2 = busy
  task automatic wait_sig(input string name, input int which, input logic val, input int bound);
    int   n = 0;
    logic s;
    s = (which == 0) ? dq_oe : (which == 1) ? err : busy;
    while (s !== val && n < bound) begin
      @(negedge clk);
      n++;
      s = (which == 0) ? dq_oe : (which == 1) ? err : busy;
    end
    chk({name, "_timeout"}, {63'd0, n >= bound}, 64'd0);
  endtask

  task automatic set_inputs(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    hum_int  = a;
    hum_dec  = b;
    temp_int = c;
    temp_dec = d;
  endtask

  initial begin
    bit saw_busy, saw_oe;
    repeat (3) @(negedge clk);
    chk("reset_oe", {63'd0, dq_oe}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_err", {63'd0, err}, 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Nominal frame; inputs change after start acceptance and must not leak in.
    set_inputs(8'h37, 8'h00, 8'h19, 8'h05);
    sb_q.push_back('{is_err: 1'b0, data: 40'h37_00_19_05_55});
    start_pulse(110);
    wait_sig("busy_rise", 2, 1'b1, 50);
    set_inputs(8'hAA, 8'h55, 8'hC3, 8'h3C);
    wait_drain("frame1", 5000);

    // Checksum wrap: 0xFF+0xFF+0x01+0x02 = 0x201 -> 0x01
    set_inputs(8'hFF, 8'hFF, 8'h01, 8'h02);
    sb_q.push_back('{is_err: 1'b0, data: 40'hFF_FF_01_02_01});
    start_pulse(110);
    wait_drain("frame_wrap", 5000);

    // Short glitch is ignored.
    saw_busy = 1'b0;
    saw_oe   = 1'b0;
    @(negedge clk);
    host_low = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if (i == 50) host_low = 1'b0;
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (dq_oe) saw_oe = 1'b1;
    end
    chk("glitch_busy", {63'd0, saw_busy}, 64'd0);
    chk("glitch_oe", {63'd0, saw_oe}, 64'd0);

    // Contention during RESP_HI aborts with one err pulse.
    set_inputs(8'h12, 8'h34, 8'h56, 8'h78);
    sb_q.push_back('{is_err: 1'b1, data: 40'd0});
    start_pulse(110);
    wait_sig("resp_lo_start", 0, 1'b1, 200);
    wait_sig("resp_hi_start", 0, 1'b0, 200);
    contend = 1'b1;
    wait_sig("err_pulse", 1, 1'b1, 200);
    contend = 1'b0;
    wait_drain("contention", 500);

    // Fresh start after the abort.
    set_inputs(8'h40, 8'h01, 8'h80, 8'hFE);
    sb_q.push_back('{is_err: 1'b0, data: 40'h40_01_80_FE_BF});
    start_pulse(110);
    wait_drain("frame_after_err", 5000);

    // Reset in the middle of bit 12: line released next cycle, no done.
    set_inputs(8'h37, 8'h00, 8'h19, 8'h05);
    start_pulse(110);
    begin
      int n = 0;
      while (!(in_frame && nbits >= 12) && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("bit12_timeout", {63'd0, n >= 3000}, 64'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_oe", {63'd0, dq_oe}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3000) @(negedge clk);
    chk("rst_no_done_queue", sb_q.size(), 0);

    // Loopback after the reset returns the original frame, temp 0x19 included.
    sb_q.push_back('{is_err: 1'b0, data: 40'h37_00_19_05_55});
    start_pulse(110);
    wait_drain("frame_after_rst", 5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
